// File: rtl/marb_pkg.sv
// Shared types and defaults for the memory arbiter grant controller.
package marb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_REQ  = 1'b1
  } arb_states_t;

  localparam int MARB_CLIENTS_DEF     = 3;
  localparam int MARB_OUTSTANDING_DEF = 4;

endpackage

// File: rtl/marb_if.sv
// Client request/response and memory-port signals of the grant controller.
interface marb_if #(
  parameter int N      = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N-1:0]        c_valid;
  logic [N-1:0]        c_ready;
  logic [N-1:0]        c_we;
  logic [N*ADDR_W-1:0] c_addr;
  logic [N*DATA_W-1:0] c_wdata;
  logic [N-1:0]        c_rsp_valid;
  logic [DATA_W-1:0]   c_rsp_rdata;
  logic                m_valid;
  logic                m_ready;
  logic                m_we;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic                m_rsp_valid;
  logic [DATA_W-1:0]   m_rsp_rdata;

  modport slave (
    input  c_valid, c_we, c_addr, c_wdata, m_ready, m_rsp_valid, m_rsp_rdata,
    output c_ready, c_rsp_valid, c_rsp_rdata, m_valid, m_we, m_addr, m_wdata
  );

  modport master (
    output c_valid, c_we, c_addr, c_wdata, m_ready, m_rsp_valid, m_rsp_rdata,
    input  c_ready, c_rsp_valid, c_rsp_rdata, m_valid, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/marb_id_fifo.sv
// FIFO of issuing client IDs for outstanding memory transactions.
module marb_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_id;
  end
endmodule

// File: rtl/marb_grant_ctrl.sv
// Picks one requesting client by priority list, issues it on the memory port and
// routes in-order memory responses back to the issuing client.
module marb_grant_ctrl
  import marb_pkg::*;
#(
  parameter int MEM_ARB_CLIENTS_P = MARB_CLIENTS_DEF,
  parameter int MEM_ADDR_W        = 32,
  parameter int MEM_DATA_W        = 32,
  parameter int OUTSTANDING_P     = MARB_OUTSTANDING_DEF,
  localparam int CLIENTS_BWIDTH_P = $clog2(MEM_ARB_CLIENTS_P)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CLIENTS_BWIDTH_P-1:0] prio_list0,
  input  logic [CLIENTS_BWIDTH_P-1:0] prio_list1,
  input  logic [CLIENTS_BWIDTH_P-1:0] prio_list2,
  marb_if.slave                       bus,
  output logic                        rsp_orphan
);
  localparam int CB = CLIENTS_BWIDTH_P;

  arb_states_t   arb_state;
  logic [CB-1:0] grant_id;
  logic [CB-1:0] prio [3];
  logic          win_found;
  logic [CB-1:0] win_id;
  logic          grant;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CB-1:0] fifo_head;

  function automatic logic [MEM_ARB_CLIENTS_P-1:0] id_onehot(input logic [CB-1:0] id);
    logic [MEM_ARB_CLIENTS_P-1:0] r;
    for (int i = 0; i < MEM_ARB_CLIENTS_P; i++) r[i] = (id == CB'(i));
    return r;
  endfunction

  assign prio[0] = prio_list0;
  assign prio[1] = prio_list1;
  assign prio[2] = prio_list2;

  // First in-range, valid entry wins; duplicates resolve to the earliest slot
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < 3; k++) begin
      if (!win_found && (prio[k] < CB'(MEM_ARB_CLIENTS_P)) && bus.c_valid[prio[k]]) begin
        win_found = 1'b1;
        win_id    = prio[k];
      end
    end
  end

  assign grant       = (arb_state == ARB_IDLE) && win_found && !fifo_full;
  assign bus.c_ready = grant ? id_onehot(win_id) : '0;
  assign fifo_push   = (arb_state == ARB_REQ) && bus.m_ready;
  assign fifo_pop    = bus.m_rsp_valid && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_state   <= ARB_IDLE;
      bus.m_valid <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      grant_id    <= '0;
    end else begin
      case (arb_state)
        ARB_IDLE: begin
          if (grant) begin
            bus.m_we    <= bus.c_we[win_id];
            bus.m_addr  <= bus.c_addr[win_id*MEM_ADDR_W +: MEM_ADDR_W];
            bus.m_wdata <= bus.c_wdata[win_id*MEM_DATA_W +: MEM_DATA_W];
            grant_id    <= win_id;
            bus.m_valid <= 1'b1;
            arb_state   <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
            arb_state   <= ARB_IDLE;
          end
        end
        default: arb_state <= ARB_IDLE;
      endcase
    end
  end

  // Response stage: one cycle from memory strobe to client strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.c_rsp_valid <= '0;
      bus.c_rsp_rdata <= '0;
      rsp_orphan      <= 1'b0;
    end else begin
      bus.c_rsp_valid <= fifo_pop ? id_onehot(fifo_head) : '0;
      if (fifo_pop) bus.c_rsp_rdata <= bus.m_rsp_rdata;
      rsp_orphan      <= bus.m_rsp_valid && fifo_empty;
    end
  end

  marb_id_fifo #(
    .WIDTH (CB),
    .DEPTH (OUTSTANDING_P)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .push_id (grant_id),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );
endmodule

// File: tb/tb_marb_grant_ctrl.sv
// Bench for marb_grant_ctrl: directed scenarios then random traffic against a queue model.
module tb_marb_grant_ctrl;
  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int OUT = 4;

  logic       clk;
  logic       rst;
  logic [1:0] pl [3];
  logic       rsp_orphan;
  int         checks;
  int         failures;

  marb_if #(.N(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  marb_grant_ctrl #(
    .MEM_ARB_CLIENTS_P (N),
    .MEM_ADDR_W        (AW),
    .MEM_DATA_W        (DW),
    .OUTSTANDING_P     (OUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prio_list0 (pl[0]),
    .prio_list1 (pl[1]),
    .prio_list2 (pl[2]),
    .bus        (bus.slave),
    .rsp_orphan (rsp_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending request plus queue of issued client IDs
  bit          busy;
  int          gid;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  int          ids [$];
  logic [2:0]  e_rv;
  logic [31:0] e_rdata;
  logic        e_orph;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < 3; k++) begin
      if (int'(pl[k]) < N && bus.c_valid[pl[k]]) return int'(pl[k]);
    end
    return -1;
  endfunction

  task automatic cycle();
    logic [2:0] ec;
    int         w;
    #1;
    w  = winner();
    ec = (!busy && w >= 0 && ids.size() < OUT) ? 3'(1 << w) : 3'b000;
    chk("c_ready", 32'(bus.c_ready), 32'(ec));
    chk("m_valid", 32'(bus.m_valid), 32'(busy));
    if (busy) begin
      chk("m_addr", bus.m_addr, addr_q);
      chk("m_wdata", bus.m_wdata, wdata_q);
      chk("m_we", 32'(bus.m_we), 32'(we_q));
    end
    e_rv   = 3'b000;
    e_orph = 1'b0;
    if (bus.m_rsp_valid) begin
      if (ids.size() > 0) begin
        e_rv    = 3'(1 << ids.pop_front());
        e_rdata = bus.m_rsp_rdata;
      end else begin
        e_orph = 1'b1;
      end
    end
    if (busy && bus.m_ready) begin
      ids.push_back(gid);
      busy = 1'b0;
    end else if (ec != 3'b000) begin
      busy    = 1'b1;
      gid     = w;
      we_q    = bus.c_we[w];
      addr_q  = bus.c_addr[w*AW +: AW];
      wdata_q = bus.c_wdata[w*DW +: DW];
    end
    if (rst) begin
      busy    = 1'b0;
      ids     = {};
      e_rv    = 3'b000;
      e_rdata = '0;
      e_orph  = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("c_rsp_valid", 32'(bus.c_rsp_valid), 32'(e_rv));
    chk("c_rsp_rdata", bus.c_rsp_rdata, e_rdata);
    chk("rsp_orphan", 32'(rsp_orphan), 32'(e_orph));
  endtask

  task automatic set_prio(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    pl[0] = a;
    pl[1] = b;
    pl[2] = c;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    busy     = 1'b0;
    gid      = 0;
    we_q     = 1'b0;
    addr_q   = '0;
    wdata_q  = '0;
    e_rdata  = '0;
    set_prio(2'd0, 2'd1, 2'd2);
    bus.c_valid     = '0;
    bus.c_we        = 3'b101;
    bus.c_addr      = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    bus.c_wdata     = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    bus.m_ready     = 1'b0;
    bus.m_rsp_valid = 1'b0;
    bus.m_rsp_rdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_c_ready", 32'(bus.c_ready), 32'h0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'h0);
    chk("rst_m_we", 32'(bus.m_we), 32'h0);
    chk("rst_m_addr", bus.m_addr, 32'h0);
    chk("rst_m_wdata", bus.m_wdata, 32'h0);
    chk("rst_c_rsp_valid", 32'(bus.c_rsp_valid), 32'h0);
    chk("rst_c_rsp_rdata", bus.c_rsp_rdata, 32'h0);
    chk("rst_orphan", 32'(rsp_orphan), 32'h0);

    // Static list, clients 1 and 2 valid: client 1 wins
    bus.c_valid = 3'b110;
    #1 chk("t1_c_ready", 32'(bus.c_ready), 32'h2);
    cycle();
    chk("t1_m_valid", 32'(bus.m_valid), 32'h1);
    chk("t1_m_addr", bus.m_addr, 32'hA000_0001);
    bus.m_ready = 1'b1;
    bus.c_valid = 3'b000;
    cycle();
    bus.m_ready = 1'b0;

    // Reversed priority, then list changes while stalled
    set_prio(2'd2, 2'd0, 2'd1);
    bus.c_valid = 3'b111;
    cycle();
    chk("t2_m_addr", bus.m_addr, 32'hA000_0002);
    set_prio(2'd0, 2'd1, 2'd2);
    repeat (5) cycle();
    chk("t2_m_addr_held", bus.m_addr, 32'hA000_0002);
    bus.m_ready = 1'b1;
    bus.c_valid = 3'b000;
    cycle();
    bus.m_ready = 1'b0;
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_rdata = 32'h1111_0001;
    cycle();
    chk("t2_rsp_c1", 32'(bus.c_rsp_valid), 32'h2);
    bus.m_rsp_rdata = 32'h1111_0002;
    cycle();
    chk("t2_rsp_c2", 32'(bus.c_rsp_valid), 32'h4);
    bus.m_rsp_valid = 1'b0;

    // Fill the ID FIFO, then one response frees a slot
    bus.m_ready = 1'b1;
    bus.c_valid = 3'b111;
    repeat (8) cycle();
    chk("t3_full_c_ready", 32'(bus.c_ready), 32'h0);
    repeat (2) cycle();
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_rdata = 32'h3333_0000;
    cycle();
    bus.m_rsp_valid = 1'b0;
    #1 chk("t3_regrant", 32'(bus.c_ready), 32'h1);
    repeat (2) cycle();
    bus.c_valid = 3'b000;
    bus.m_rsp_valid = 1'b1;
    repeat (4) cycle();
    bus.m_rsp_valid = 1'b0;

    // Issue clients 1,0,2 and check in-order routing
    bus.c_valid = 3'b010; cycle(); bus.c_valid = 3'b000; cycle();
    bus.c_valid = 3'b001; cycle(); bus.c_valid = 3'b000; cycle();
    bus.c_valid = 3'b100; cycle(); bus.c_valid = 3'b000; cycle();
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_rdata = 32'hAAAA_AAAA;
    cycle();
    chk("t4_rv_A", 32'(bus.c_rsp_valid), 32'h2);
    chk("t4_data_A", bus.c_rsp_rdata, 32'hAAAA_AAAA);
    bus.m_rsp_rdata = 32'hBBBB_BBBB;
    cycle();
    chk("t4_rv_B", 32'(bus.c_rsp_valid), 32'h1);
    chk("t4_data_B", bus.c_rsp_rdata, 32'hBBBB_BBBB);
    bus.m_rsp_rdata = 32'hCCCC_CCCC;
    cycle();
    chk("t4_rv_C", 32'(bus.c_rsp_valid), 32'h4);
    chk("t4_data_C", bus.c_rsp_rdata, 32'hCCCC_CCCC);
    bus.m_rsp_valid = 1'b0;
    cycle();
    chk("t4_rv_idle", 32'(bus.c_rsp_valid), 32'h0);
    chk("t4_data_hold", bus.c_rsp_rdata, 32'hCCCC_CCCC);

    // Push and pop in the same cycle with one entry outstanding
    bus.c_valid = 3'b001; cycle(); bus.c_valid = 3'b000; cycle();
    bus.m_ready = 1'b0;
    bus.c_valid = 3'b100;
    cycle();
    bus.c_valid = 3'b000;
    bus.m_ready = 1'b1;
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_rdata = 32'h5555_0000;
    cycle();
    chk("t5_rv_c0", 32'(bus.c_rsp_valid), 32'h1);
    bus.m_ready = 1'b0;
    bus.m_rsp_rdata = 32'h5555_0002;
    cycle();
    chk("t5_rv_c2", 32'(bus.c_rsp_valid), 32'h4);
    chk("t5_data_c2", bus.c_rsp_rdata, 32'h5555_0002);

    // Orphan response, then reset during an outstanding request
    cycle();
    chk("t6_orphan", 32'(rsp_orphan), 32'h1);
    chk("t6_orphan_rv", 32'(bus.c_rsp_valid), 32'h0);
    bus.m_rsp_valid = 1'b0;
    cycle();
    chk("t6_orphan_end", 32'(rsp_orphan), 32'h0);
    bus.c_valid = 3'b010;
    cycle();
    chk("t6_req_valid", 32'(bus.m_valid), 32'h1);
    bus.c_valid = 3'b000;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_rst_m_valid", 32'(bus.m_valid), 32'h0);
    bus.m_rsp_valid = 1'b1;
    cycle();
    chk("t6_lost_orphan", 32'(rsp_orphan), 32'h1);
    bus.m_rsp_valid = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_prio(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      bus.c_valid     = 3'($urandom);
      bus.c_we        = 3'($urandom);
      bus.c_addr      = {$urandom, $urandom, $urandom};
      bus.c_wdata     = {$urandom, $urandom, $urandom};
      bus.m_ready     = 1'($urandom);
      bus.m_rsp_valid = ($urandom_range(0, 2) == 0);
      bus.m_rsp_rdata = $urandom;
      rst             = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
